sensor_conditioner: RTL and testbench
=====================================

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive clocks a synchronized raw level must hold before it propagates; legal range 2..65535.
REQ-002 Parameter STUCK_CYCLES, default 1000000, is the number of consecutive clocks a debounced sensor may stay asserted before its fault bit sets; legal range > DEBOUNCE_CYCLES.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 raw_s  input  4  unsynchronized track sensor inputs; bit 0 = sensor 1 ... bit 3 = sensor 4; 1 = train present.
REQ-006 s1, s2, s3, s4  output  1 each  conditioned sensor outputs, driving the track controller's s1..s4 inputs.
REQ-007 stuck  output  4  sticky per-channel fault flags, bit i for sensor i+1.

Function
REQ-008 Each raw_s bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-009 Each channel SHALL hold a debounced level deb_i and a counter of width clog2(DEBOUNCE_CYCLES)+1.
REQ-010 Counter SHALL clear on any edge where the synchronized bit equals deb_i, and increment on any edge where it differs.
REQ-011 deb_i SHALL invert, and the counter clear, on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-012 A raw change held stable SHALL appear on deb_i at the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new value as edge 1.
REQ-013 A raw pulse shorter than DEBOUNCE_CYCLES clocks after synchronization SHALL produce no output change.
REQ-014 A glitch back to the old level mid-count SHALL restart the count from zero, with no partial credit.
REQ-015 Channels SHALL be fully independent; simultaneous changes on several channels SHALL propagate on the same edge.
REQ-016 A per-channel stuck counter SHALL increment while deb_i = 1, clear while deb_i = 0, and saturate at STUCK_CYCLES without wrapping.
REQ-017 stuck[i] SHALL set on the edge the stuck counter reaches STUCK_CYCLES and remain set until reset, regardless of later sensor activity.
REQ-018 The outputs SHALL be registered, with no combinational path from raw_s to s1..s4 or stuck.

Reset
REQ-019 While rst = 1, the following SHALL be held at 0 asynchronously: synchronizer flops, deb_i, debounce counters, stuck counters, stuck, and s1..s4.
REQ-020 Reset asserted mid-debounce SHALL discard the partial count.
REQ-021 After rst deasserts, a raw input already at 1 SHALL propagate with the full REQ-012 latency.

Configuration
REQ-022 Macro SENSOR_PULSE_EN SHALL select the output mode.
REQ-023 With SENSOR_PULSE_EN defined, s1..s4 SHALL be one-clock pulses asserted on the edge after deb_i rises 0->1, and SHALL stay low on deb_i falling.
REQ-024 With SENSOR_PULSE_EN undefined, s1..s4 SHALL equal deb_i registered, i.e. one clock after deb_i.
REQ-025 Debounce and stuck behaviour SHALL be identical in both modes.

Verification
REQ-026 Test 1, level mode, DEBOUNCE_CYCLES=4: raw_s[0] 0->1 held -> s1 rises at edge 7 (deb at edge 6 + 1 output register) and stays high; other outputs stay 0.
REQ-027 Test 2, glitch: raw_s[1] high for 3 clocks then low -> s2 never asserts; raw_s[1] high 3, low 1, high 6 -> s2 rises only after the final high run completes 4 synchronized clocks.
REQ-028 Test 3, simultaneous: raw_s 0000->1111 in one cycle -> s1..s4 rise on the same edge; 1111->0000 -> s1..s4 fall on the same edge.
REQ-029 Test 4, stuck with STUCK_CYCLES=20: raw_s[3] held high -> stuck = 4'b1000 after the 20th clock of deb high; raw_s[3] released -> stuck stays 4'b1000 until rst.
REQ-030 Test 5, reset mid-count: rst pulsed for 1 clock while the raw_s[2] count is 3 of 4 -> s3 stays 0 and needs a full 6 edges after reset release to rise.
REQ-031 Test 6, SENSOR_PULSE_EN defined: raw_s[0] held high for 50 clocks -> s1 is high for exactly 1 clock; the falling raw edge produces no pulse.

Source files
------------

// File: rtl/sensor_if.sv
// sensor_if: raw track sensor inputs and conditioned outputs of sensor_conditioner.
interface sensor_if;
   logic [3:0] raw_s;
   logic       s1, s2, s3, s4;
   logic [3:0] stuck;
   modport master (output raw_s, input s1, s2, s3, s4, stuck);
   modport slave (input raw_s, output s1, s2, s3, s4, stuck);
endinterface

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: synchronize, debounce and stuck-detect four track sensors.
// Define SENSOR_PULSE_EN for one-clock rising-edge pulses on s1..s4 instead of levels.
module sensor_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STUCK_CYCLES    = 1000000
) (
   input logic     clk,
   input logic     rst,
   sensor_if.slave bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int SW = $clog2(STUCK_CYCLES + 1);
   logic [3:0]    sync1, sync2, deb, s, stuck, s_next;
   logic [CW-1:0] cnt [4];
   logic [SW-1:0] scnt [4];

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         s     <= '0;
         stuck <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt[i]  <= '0;
            scnt[i] <= '0;
         end
      end else begin
         sync1 <= bus.raw_s;
         sync2 <= sync1;
         s     <= s_next;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == deb[i]) cnt[i] <= '0;
            else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               deb[i] <= ~deb[i];
               cnt[i] <= '0;
            end else cnt[i] <= cnt[i] + CW'(1);
            // saturating run length of the debounced high level; fault latches until reset
            if (!deb[i]) scnt[i] <= '0;
            else if (scnt[i] != SW'(STUCK_CYCLES)) scnt[i] <= scnt[i] + SW'(1);
            if (deb[i] && scnt[i] == SW'(STUCK_CYCLES - 1)) stuck[i] <= 1'b1;
         end
      end

`ifdef SENSOR_PULSE_EN
   logic [3:0] deb_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) deb_q <= '0;
      else deb_q <= deb;
   always_comb s_next = deb & ~deb_q;
`else
   always_comb s_next = deb;
`endif

   assign bus.s1    = s[0];
   assign bus.s2    = s[1];
   assign bus.s3    = s[2];
   assign bus.s4    = s[3];
   assign bus.stuck = stuck;
endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner: directed and random stimulus checked against a sliding-window model.
module tb_sensor_conditioner;
   localparam int D = 4;
   localparam int S = 20;
`ifdef SENSOR_PULSE_EN
   localparam bit PULSE = 1'b1;
`else
   localparam bit PULSE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   bit   run = 1'b0;

   sensor_if bus();
   sensor_conditioner #(.DEBOUNCE_CYCLES(D), .STUCK_CYCLES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Model: deb flips when the last D synchronized samples all disagree with it.
   logic [3:0] hist [0:D];
   logic [3:0] mdeb = '0, mdeb_q = '0, ms = '0, mstuck = '0, old;
   int         edge_n = 0;
   int         rise_at [4];
   bit         all_diff;

   always @(posedge clk or posedge rst)
      if (rst) begin
         for (int k = 0; k <= D; k++) hist[k] = '0;
         mdeb = '0; mdeb_q = '0; ms = '0; mstuck = '0; edge_n = 0;
      end else begin
         edge_n++;
         old = mdeb;
         ms = PULSE ? (old & ~mdeb_q) : old;
         mdeb_q = old;
         for (int i = 0; i < 4; i++) begin
            if (old[i] && edge_n - rise_at[i] == S) mstuck[i] = 1'b1;
            all_diff = 1'b1;
            for (int k = 1; k <= D; k++) if (hist[k][i] == old[i]) all_diff = 1'b0;
            if (all_diff) begin
               mdeb[i] = ~old[i];
               if (!old[i]) rise_at[i] = edge_n;
            end
         end
         for (int k = D; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = bus.raw_s;
      end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (run) begin
         check("model_s", 32'({bus.s4, bus.s3, bus.s2, bus.s1}), 32'(ms));
         check("model_stuck", 32'(bus.stuck), 32'(mstuck));
      end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   function automatic logic [3:0] outs();
      return {bus.s4, bus.s3, bus.s2, bus.s1};
   endfunction

   int hi_cnt;
   int rate;

   initial begin
      bus.raw_s = '0;
      #1 rst = 1'b1;
      run = 1'b1;
      tick(3);
      check("reset_s", 32'(outs()), 0);
      check("reset_stuck", 32'(bus.stuck), 0);
      rst = 1'b0;
      tick(2);
      // level propagation latency
      bus.raw_s = 4'b0001;
      tick(6);
      check("t1_edge6", 32'(bus.s1), 0);
      tick(1);
      check("t1_edge7", 32'(bus.s1), 1);
      tick(5);
      check("t1_hold", 32'(bus.s1), PULSE ? 0 : 1);
      check("t1_others", 32'(outs() & 4'b1110), 0);
      bus.raw_s = '0;
      tick(10);
      check("t1_fall", 32'(outs()), 0);
      // short pulse and glitch restart
      bus.raw_s = 4'b0010;
      tick(3);
      bus.raw_s = '0;
      tick(10);
      check("t2_short", 32'(bus.s2), 0);
      bus.raw_s = 4'b0010; tick(3);
      bus.raw_s = '0;      tick(1);
      bus.raw_s = 4'b0010;
      tick(6);
      check("t2_glitch_edge6", 32'(bus.s2), 0);
      tick(1);
      check("t2_glitch_edge7", 32'(bus.s2), 1);
      bus.raw_s = '0;
      tick(10);
      // simultaneous rise and fall
      bus.raw_s = 4'b1111;
      tick(6);
      check("t3_rise6", 32'(outs()), 0);
      tick(1);
      check("t3_rise7", 32'(outs()), 4'b1111);
      bus.raw_s = '0;
      tick(6);
      check("t3_fall6", 32'(outs()), PULSE ? 0 : 4'b1111);
      tick(1);
      check("t3_fall7", 32'(outs()), 0);
      tick(5);
      // stuck detection: deb rises at edge 6, fault at edge 26
      bus.raw_s = 4'b1000;
      tick(25);
      check("t4_pre", 32'(bus.stuck), 0);
      tick(1);
      check("t4_set", 32'(bus.stuck), 4'b1000);
      bus.raw_s = '0;
      tick(20);
      check("t4_sticky", 32'(bus.stuck), 4'b1000);
      check("t4_s4_low", 32'(bus.s4), 0);
      rst = 1'b1; tick(1); rst = 1'b0;
      check("t4_cleared", 32'(bus.stuck), 0);
      tick(2);
      // reset mid-count discards progress
      bus.raw_s = 4'b0100;
      tick(5);
      rst = 1'b1; tick(1); rst = 1'b0;
      tick(6);
      check("t5_edge6", 32'(bus.s3), 0);
      tick(1);
      check("t5_edge7", 32'(bus.s3), 1);
      bus.raw_s = '0;
      tick(10);
      // output mode: count high samples on s1 over a 50-clock hold
      hi_cnt = 0;
      bus.raw_s = 4'b0001;
      for (int c = 0; c < 70; c++) begin
         if (c == 50) bus.raw_s = '0;
         tick(1);
         if (bus.s1) hi_cnt++;
      end
      check("t6_high_cycles", 32'(hi_cnt), PULSE ? 1 : 50);
      // random traffic with fast and slow toggle phases plus one reset
      for (int c = 0; c < 900; c++) begin
         rate = (c % 300 < 150) ? 5 : 40;
         if ($urandom_range(0, rate) == 0) bus.raw_s = bus.raw_s ^ 4'($urandom_range(1, 15));
         if (c == 450) rst = 1'b1;
         if (c == 452) rst = 1'b0;
         tick(1);
      end
      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
